// File: rtl/byte_frame_if.sv
// byte_frame_if: valid/ready byte link into a frame responder, plus its occupancy readout
interface byte_frame_if #(parameter int DATA_W = 8, parameter int DEPTH = 4);
  logic [DATA_W-1:0]        data_in;
  logic                     in_valid;
  logic                     in_last;
  logic                     in_ready;
  logic [DATA_W-1:0]        data_out;
  logic                     out_valid;
  logic                     out_last;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   level;
  modport master (output data_in, in_valid, in_last, out_ready,
                  input  in_ready, data_out, out_valid, out_last, level);
  modport slave  (input  data_in, in_valid, in_last, out_ready,
                  output in_ready, data_out, out_valid, out_last, level);
endinterface

// File: rtl/byte_frame_responder.sv
// byte_frame_responder: buffers framed bytes in a FIFO and replays each frame followed by its XOR checksum
module byte_frame_responder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  byte_frame_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {PASS, CSUM} state_t;
  state_t            state, state_nx;
  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt;
  logic [DATA_W-1:0] csum;
  logic [DATA_W:0]   head;
  logic              push, pop;
  assign head = mem[rd_ptr];
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = state == PASS && bus.out_valid && bus.out_ready;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.in_last, bus.data_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= PASS;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == PASS && pop && head[DATA_W]) state_nx = CSUM;
    else if (state == CSUM && bus.out_ready) state_nx = PASS;
  end
  always_comb begin
    bus.in_ready  = cnt != (AW+1)'(DEPTH);
    bus.out_valid = state == CSUM ? 1'b1 : cnt != '0;
    bus.data_out  = state == CSUM ? csum : (cnt != '0 ? head[DATA_W-1:0] : '0);
    bus.out_last  = state == CSUM;
    bus.level     = cnt;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      csum   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) cnt <= push ? cnt + (AW+1)'(1) : cnt - (AW+1)'(1);
      csum <= pop ? csum ^ head[DATA_W-1:0] : (state == CSUM && bus.out_ready) ? '0 : csum;
    end
endmodule

// File: tb/tb_byte_frame_responder.sv
// tb_byte_frame_responder: scoreboard bench replaying frames and checking bytes plus XOR checksums
module tb_byte_frame_responder;
  logic clk = 0;
  logic rst_n = 0;
  int   errors = 0;
  int   checks = 0;
  logic [8:0] sb_q [$];
  logic [7:0] m_csum = 0;
  byte_frame_if #(.DATA_W(8), .DEPTH(4)) bus ();
  byte_frame_responder #(.DATA_W(8), .DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) check("sb_empty", 32'(sb_q.size()), 1);
      else check("out", {23'd0, bus.out_last, bus.data_out}, {23'd0, sb_q.pop_front()});
    end
  task automatic send(input logic [7:0] d, input logic last);
    bit taken = 0;
    bus.data_in  = d;
    bus.in_last  = last;
    bus.in_valid = 1;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        taken = 1;
        sb_q.push_back({1'b0, d});
        m_csum ^= d;
        if (last) begin
          sb_q.push_back({1'b1, m_csum});
          m_csum = 0;
        end
      end
      @(posedge clk);
      #1;
    end
    if (!taken) check("push_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 32'(sb_q.size()), 0);
    @(posedge clk);
    #1;
    check("idle_valid", 32'(bus.out_valid), 0);
  endtask
  task automatic wait_csum();
    int n = 0;
    bus.out_ready = 1;
    while (!bus.out_last && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    bus.out_ready = 0;
    check("reach_csum", 32'(bus.out_last), 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 0);
    check({tag, "_last"}, 32'(bus.out_last), 0);
    check({tag, "_data"}, 32'(bus.data_out), 0);
    check({tag, "_ready"}, 32'(bus.in_ready), 1);
    check({tag, "_level"}, 32'(bus.level), 0);
  endtask
  initial begin
    bus.data_in = 0; bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.data_in = 8'($urandom); bus.in_valid = 1'($urandom);
      bus.in_last = 1'($urandom); bus.out_ready = 1'($urandom);
      #1;
      check_reset_outputs("rst");
    end
    bus.data_in = 0; bus.in_valid = 0; bus.in_last = 0; bus.out_ready = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (5) @(posedge clk);
    #1;
    check_reset_outputs("idle");
    bus.out_ready = 1;
    send(8'h12, 0);
    check("first_valid", 32'(bus.out_valid), 1);
    send(8'h34, 0);
    send(8'h56, 1);
    drain();
    bus.out_ready = 0;
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 0);
    check("bp_level", 32'(bus.level), 4);
    check("bp_ready", 32'(bus.in_ready), 0);
    fork
      send(8'hA4, 1);
      begin
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_level", 32'(bus.level), 4);
        check("bp_hold_data", 32'(bus.data_out), 32'hA0);
        bus.out_ready = 1;
      end
    join
    drain();
    send(8'h01, 0);
    send(8'h02, 1);
    send(8'hFF, 1);
    send(8'hA5, 1);
    drain();
    bus.out_ready = 0;
    send(8'h11, 0);
    send(8'h22, 1);
    wait_csum();
    foreach (sb_q[i]) ;
    send(8'h33, 0);
    check("stall_data0", 32'(bus.data_out), 32'h33);
    send(8'h44, 0);
    check("stall_last", 32'(bus.out_last), 1);
    send(8'h55, 1);
    check("stall_data2", {31'd0, bus.out_last} << 8 | 32'(bus.data_out), 32'h133);
    check("stall_level", 32'(bus.level), 3);
    bus.out_ready = 1;
    drain();
    bus.out_ready = 0;
    send(8'hAB, 0);
    send(8'hCD, 1);
    wait_csum();
    #2;
    rst_n = 0;
    #1;
    check_reset_outputs("arst");
    sb_q.delete();
    m_csum = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    bus.out_ready = 1;
    send(8'h0F, 0);
    send(8'hF0, 1);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/byte_frame_responder.md
# byte_frame_responder

Downstream byte-stream endpoint for an 8-bit `data_in`/`data_out` link between sibling blocks. It accepts framed bytes through a valid/ready handshake and buffers them in a small FIFO. It replays each frame on the output, then appends one XOR checksum byte at the end of the frame. Parents instantiate it as the receiving end of their byte link.

## Interface
- `DATA_W`, 8: byte width; fixed at 8, and other values are unsupported.
- `DEPTH`, 4: FIFO entries; must be a power of two and at least 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data_in` input 8: input byte.
- `in_valid` input 1: `data_in`/`in_last` are valid.
- `in_last` input 1: marks the final byte of a frame.
- `in_ready` output 1: FIFO can accept a byte.
- `data_out` output 8: output byte.
- `out_valid` output 1: `data_out` is valid.
- `out_last` output 1: asserted only on the checksum byte.
- `out_ready` input 1: consumer accepts `data_out`.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push: occurs when `in_valid && in_ready`. Stores {`in_last`, `data_in`} at the write pointer.
- `in_ready = (level != DEPTH)`. There is no push-when-full bypass, even if a pop occurs in the same cycle.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally.
- `level` is +1 on push only, −1 on pop only, and unchanged on simultaneous push and pop.
- FSM has two states, PASS and CSUM. PASS is the reset state.
- PASS:
  - `out_valid = (level != 0)`.
  - `data_out` = head data, or 0 when empty.
  - `out_last = 0`.
- Pop in PASS: occurs when `out_valid && out_ready`.
  - `csum <= csum ^ head_data`.
  - If the head last-flag is set, go to CSUM.
- CSUM:
  - `out_valid = 1`, `data_out = csum`, `out_last = 1`.
  - No FIFO pop occurs; pushes continue normally.
  - On `out_ready`: go to PASS and set `csum <= 0`.
- Checksum is the 8-bit XOR of every data byte in the frame. Checksum bytes themselves are excluded.
- A single-byte frame yields that byte twice; the second copy carries `out_last`.
- No frame length limit. Frames longer than `DEPTH` stream through under backpressure.
- `in_valid` with `in_ready = 0`: the byte is not taken. The source must hold it stable (standard valid/ready rules).
- `out_valid`, once high, stays high with `data_out` stable until `out_ready` is seen. PASS→CSUM only follows a handshake, so this holds automatically.

## Timing
- Reset (`rst_n` low, asynchronous) applies immediately, without waiting for a clock edge:
  - Pointers = 0, `level` = 0, state = PASS, `csum` = 0.
  - Hence `out_valid` = 0, `data_out` = 0, `out_last` = 0, `in_ready` = 1.
  - FIFO storage contents need no reset.
- Reset mid-frame or during CSUM discards all buffered bytes and the partial checksum.
- Latency: a byte pushed at edge N appears on `data_out` with `out_valid` after edge N (combinational from registered state). Minimum 1 cycle.
- Throughput: 1 byte per cycle in PASS. Each frame costs one extra output cycle for its checksum.
- The output is combinational from registers only. There is no combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.
- Full with simultaneous pop: `in_ready` is 0 that cycle. The push takes effect on the following cycle at the earliest.

## Test plan
- Reset: hold `rst_n` = 0 with random inputs. Require `out_valid` = 0, `out_last` = 0, `data_out` = 0x00, `in_ready` = 1, `level` = 0. Release, then idle 5 cycles: outputs stay the same.
- Basic frame: push 0x12, 0x34, 0x56 (last) with `out_ready` = 1.
  - Output is 0x12, 0x34, 0x56, 0x70.
  - `out_last` is high only on 0x70.
  - First `out_valid` is one cycle after the first push.
- Backpressure (`DEPTH` = 4): hold `out_ready` = 0 and push 0xA0..0xA4 (last on 0xA4).
  - After 4 pushes, `level` = 4, `in_ready` = 0, and 0xA4 is held.
  - Raise `out_ready`: output is A0, A1, A2, A3, A4, then 0xA4 (`out_last`).
  - Checksum: A0^A1^A2^A3^A4 = 0xA4.
- Back-to-back frames: push 0x01, 0x02 (last), 0xFF (last), 0xA5 (last) continuously.
  - Output is 01, 02, 03L, FF, FFL, A5, A5L.
  - Verifies checksum clearing and single-byte frames.
- CSUM stall: stall `out_ready` = 0 for 3 cycles while the checksum is presented, with pushes of a new frame ongoing.
  - `data_out` and `out_last` stay stable.
  - `level` rises.
  - The next frame's checksum is correct.
- Async reset during CSUM: pulse `rst_n` low between edges.
  - Outputs clear immediately.
  - A new frame 0x0F, 0xF0 (last) yields 0F, F0, FFL, with no stale state.
